// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Holds the FSM state type, the opcode map, the ALU function codes, the
// flag bit positions, the decoded-instruction record passed from
// cu_decoder to the top, and a helper that evaluates jump conditions.
package cu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALT
    } cuState_t;

    // ALU instruction groups, group = opcode[6:2] for opcodes up to LAST_ALU_OP
    localparam logic [4:0] GRP_MOV = 5'd0;
    localparam logic [4:0] GRP_ADD = 5'd1;
    localparam logic [4:0] GRP_SUB = 5'd2;
    localparam logic [4:0] GRP_AND = 5'd3;
    localparam logic [4:0] GRP_OR  = 5'd4;
    localparam logic [4:0] GRP_NOT = 5'd5;
    localparam logic [4:0] GRP_XOR = 5'd6;
    localparam logic [4:0] GRP_SHL = 5'd7;
    localparam logic [4:0] GRP_SHR = 5'd8;

    localparam logic [6:0] LAST_ALU_OP = 7'h23;
    localparam logic [6:0] OP_INC_B    = 7'h24;
    localparam logic [6:0] OP_CMP_AB   = 7'h25;
    localparam logic [6:0] OP_CMP_LIT  = 7'h26;
    localparam logic [6:0] OP_JMP      = 7'h27;
    localparam logic [6:0] OP_JEQ      = 7'h28;
    localparam logic [6:0] OP_JNE      = 7'h29;
    localparam logic [6:0] OP_JGT      = 7'h2A;
    localparam logic [6:0] OP_JLT      = 7'h2B;
    localparam logic [6:0] OP_JCR      = 7'h2C;
    localparam logic [6:0] OP_LD       = 7'h2D;
    localparam logic [6:0] OP_ST       = 7'h2E;
    localparam logic [6:0] OP_HALT     = 7'h7F;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;
    localparam logic [3:0] ALU_INC = 4'b1000;
    localparam logic [3:0] ALU_MOV = 4'b1001;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [3:0] aluOp;
        logic       muxASel;
        logic       muxBSel;
        logic       regALoad;
        logic       regBLoad;
        logic       setsFlags;
        logic       isJump;
        logic       isMem;
        logic       isStore;
        logic       isHalt;
        logic       isIllegal;
    } decode_t;

    // Jump decision from the registered flags; non-jump opcodes never take
    function automatic logic jumpTaken(input logic [6:0] op, input logic z,
                                       input logic n, input logic c);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JEQ:  taken = z;
            OP_JNE:  taken = !z;
            OP_JGT:  taken = !z && !n;
            OP_JLT:  taken = n;
            OP_JCR:  taken = c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// cu_decoder: purely combinational instruction decode.
// Ports:
//   ir  in  7         latched instruction opcode
//   dec out decode_t  ALU function, operand selects, destination loads and
//                     instruction class flags (flag-setting, jump, memory,
//                     store, halt, illegal)
module cu_decoder
    import cu_pkg::*;
(
    input  logic [6:0] ir,
    output decode_t    dec
);

    logic [4:0] grp;

    assign grp = ir[6:2];

    // Two-operand groups use bit0 as the destination and bit1 as the literal
    // select; the unary shift/NOT groups use bit1 as destination and bit0 as
    // the A-operand select. Everything above the ALU range is a one-off opcode.
    always_comb begin
        dec = '0;
        if (ir <= LAST_ALU_OP) begin
            case (grp)
                GRP_MOV: dec.aluOp = ALU_MOV;
                GRP_ADD: dec.aluOp = ALU_ADD;
                GRP_SUB: dec.aluOp = ALU_SUB;
                GRP_AND: dec.aluOp = ALU_AND;
                GRP_OR:  dec.aluOp = ALU_OR;
                GRP_NOT: dec.aluOp = ALU_NOT;
                GRP_XOR: dec.aluOp = ALU_XOR;
                GRP_SHL: dec.aluOp = ALU_SHL;
                GRP_SHR: dec.aluOp = ALU_SHR;
                default: dec.aluOp = ALU_ADD;
            endcase
            if (grp == GRP_NOT || grp == GRP_SHL || grp == GRP_SHR) begin
                dec.muxASel  = ir[0];
                dec.regBLoad = ir[1];
                dec.regALoad = !ir[1];
            end else begin
                dec.muxASel  = ir[0] & ir[1];
                dec.muxBSel  = ir[1];
                dec.regBLoad = ir[0];
                dec.regALoad = !ir[0];
            end
            dec.setsFlags = (grp != GRP_MOV);
        end else begin
            case (ir)
                OP_INC_B: begin
                    dec.aluOp     = ALU_INC;
                    dec.muxASel   = 1'b1;
                    dec.regBLoad  = 1'b1;
                    dec.setsFlags = 1'b1;
                end
                OP_CMP_AB: begin
                    dec.aluOp     = ALU_SUB;
                    dec.setsFlags = 1'b1;
                end
                OP_CMP_LIT: begin
                    dec.aluOp     = ALU_SUB;
                    dec.muxBSel   = 1'b1;
                    dec.setsFlags = 1'b1;
                end
                OP_JMP, OP_JEQ, OP_JNE, OP_JGT, OP_JLT, OP_JCR: dec.isJump = 1'b1;
                OP_LD:   dec.isMem = 1'b1;
                OP_ST: begin
                    dec.isMem   = 1'b1;
                    dec.isStore = 1'b1;
                end
                OP_HALT: dec.isHalt = 1'b1;
                default: dec.isIllegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/EXEC sequencer for the A/B-register CPU.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              leave IDLE/HALT and fetch at the current PC
//   opcode             instruction memory output at PC
//   alu_flags          live ALU flags (Z,N,C,V in bits 0..3)
//   mem_ack            one-cycle data memory completion
//   alu_op, muxA_sel, muxB_sel, regA_load, regB_load   datapath controls
//   pc_inc, pc_load    program counter controls
//   mem_req, mem_we    data memory request / write enable
//   flags_q            registered status flags
//   halted, illegal_op, mem_timeout   status indications
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int ALU_OP_W    = 4,
    parameter int FLAG_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   alu_flags,
    input  logic                mem_ack,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                muxA_sel,
    output logic                muxB_sel,
    output logic                regA_load,
    output logic                regB_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mem_req,
    output logic                mem_we,
    output logic [FLAG_W-1:0]   flags_q,
    output logic                halted,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    cuState_t            state;
    logic [OPCODE_W-1:0] ir;
    logic [FLAG_W-1:0]   flagsQ;
    logic [CNT_W-1:0]    waitCnt;
    decode_t             dec;
    logic                jumpGo;
    logic                timeoutHit;
    logic                memDone;

    cu_decoder decoder (
        .ir  (ir),
        .dec (dec)
    );

    assign jumpGo     = jumpTaken(ir, flagsQ[FLAG_Z], flagsQ[FLAG_N], flagsQ[FLAG_C]);
    assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt == LAST_WAIT);
    assign memDone    = mem_ack || timeoutHit;
    assign flags_q    = flagsQ;

    // Sequencer: IR is captured in FETCH, flags are captured at the end of a
    // flag-setting EXEC, and waitCnt counts MEM cycles already spent so the
    // final permitted cycle is the one where waitCnt reaches LAST_WAIT.
    // Leaving MEM always clears the counter so the next access starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= '0;
            flagsQ  <= '0;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end
                FETCH: begin
                    ir    <= opcode;
                    state <= EXEC;
                end
                EXEC: begin
                    if (dec.setsFlags) flagsQ <= alu_flags;
                    if (dec.isMem)       state <= MEM;
                    else if (dec.isHalt) state <= HALT;
                    else                 state <= FETCH;
                end
                MEM: begin
                    if (memDone) begin
                        waitCnt <= '0;
                        state   <= FETCH;
                    end else if (MEM_TIMEOUT != 0) begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                HALT: begin
                    if (start) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from state and IR. Only the MEM completion strobes look
    // at mem_ack, so a load can write A in the same cycle the memory answers.
    // LD/ST and HALT hold off pc_inc in EXEC: memory bumps the PC when the
    // access finishes, and HALT must resume at the same address.
    always_comb begin
        alu_op      = '0;
        muxA_sel    = 1'b0;
        muxB_sel    = 1'b0;
        regA_load   = 1'b0;
        regB_load   = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            EXEC: begin
                alu_op     = ALU_OP_W'(dec.aluOp);
                muxA_sel   = dec.muxASel;
                muxB_sel   = dec.muxBSel;
                regA_load  = dec.regALoad;
                regB_load  = dec.regBLoad;
                illegal_op = dec.isIllegal;
                if (dec.isJump) begin
                    pc_load = jumpGo;
                    pc_inc  = !jumpGo;
                end else if (!dec.isMem && !dec.isHalt) begin
                    pc_inc = 1'b1;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = dec.isStore;
                if (mem_ack) begin
                    regA_load = !dec.isStore;
                    pc_inc    = 1'b1;
                end else if (timeoutHit) begin
                    mem_timeout = 1'b1;
                    pc_inc      = 1'b1;
                end
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each issued instruction
// pushes the cycle records it should produce; a negedge monitor pops one
// record for every cycle in which the DUT shows any strobe.
module tb_multicycle_control_unit;

    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] opcode = '0;
    logic [3:0] alu_flags = '0;
    logic       mem_ack = 1'b0;
    logic [3:0] alu_op;
    logic       muxA_sel, muxB_sel, regA_load, regB_load, pc_inc, pc_load;
    logic       mem_req, mem_we, halted, illegal_op, mem_timeout;
    logic [3:0] flags_q;

    typedef struct packed {
        logic [3:0] aluOp;
        logic       muxA;
        logic       muxB;
        logic       regA;
        logic       regB;
        logic       pcInc;
        logic       pcLoad;
        logic       memReq;
        logic       memWe;
        logic       halted;
        logic       illegal;
        logic       tmo;
        logic [3:0] flags;
    } rec_t;

    rec_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    bit         monitorOn = 1'b0;
    logic [3:0] modelFlags = '0;

    multicycle_control_unit #(
        .OPCODE_W(7), .ALU_OP_W(4), .FLAG_W(4), .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .alu_flags(alu_flags), .mem_ack(mem_ack), .alu_op(alu_op),
        .muxA_sel(muxA_sel), .muxB_sel(muxB_sel), .regA_load(regA_load),
        .regB_load(regB_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .mem_req(mem_req), .mem_we(mem_we), .flags_q(flags_q),
        .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Instruction-level reference: what the EXEC cycle of one non-memory,
    // non-halt instruction should show, given the flags held before it.
    function automatic rec_t modelExec(input logic [6:0] op, input logic [3:0] fl);
        rec_t       r;
        logic [3:0] aluTab [0:8];
        int         g;
        logic       lo, hi, z, n, c, taken;
        aluTab = '{4'h9, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        r = '0;
        r.flags = fl;
        r.pcInc = 1'b1;
        g  = int'(op) / 4;
        lo = op[0];
        hi = op[1];
        z  = fl[0];
        n  = fl[1];
        c  = fl[2];
        if (op <= 7'h23) begin
            r.aluOp = aluTab[g];
            if (g == 5 || g == 7 || g == 8) begin
                r.muxA = lo;
                r.regB = hi;
                r.regA = !hi;
            end else begin
                r.muxA = lo & hi;
                r.muxB = hi;
                r.regB = lo;
                r.regA = !lo;
            end
        end else if (op == 7'h24) begin
            r.aluOp = 4'h8;
            r.muxA  = 1'b1;
            r.regB  = 1'b1;
        end else if (op == 7'h25 || op == 7'h26) begin
            r.aluOp = 4'h1;
            r.muxB  = (op == 7'h26);
        end else if (op >= 7'h27 && op <= 7'h2C) begin
            case (op)
                7'h27:   taken = 1'b1;
                7'h28:   taken = z;
                7'h29:   taken = !z;
                7'h2A:   taken = !z && !n;
                7'h2B:   taken = n;
                default: taken = c;
            endcase
            r.pcLoad = taken;
            r.pcInc  = !taken;
        end else begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    function automatic bit modelSetsFlags(input logic [6:0] op);
        return (op >= 7'h04 && op <= 7'h26);
    endfunction

    // Issue one instruction starting at a FETCH cycle (called just after a
    // posedge). ackAt>MT means memory never answers; haltWait is the number
    // of idle HALT cycles before start is pulsed.
    task automatic applyStimulus(input logic [6:0] op, input logic [3:0] fl,
                                 input int ackAt, input int haltWait);
        rec_t r;
        int   n;
        bit   isMem;
        isMem = (op == 7'h2D || op == 7'h2E);
        if (isMem) begin
            n = (ackAt <= MT) ? ackAt : MT;
            for (int j = 1; j <= n; j++) begin
                r = '0;
                r.memReq = 1'b1;
                r.memWe  = (op == 7'h2E);
                r.flags  = modelFlags;
                if (j == n) begin
                    r.pcInc = 1'b1;
                    if (ackAt <= MT) r.regA = (op == 7'h2D);
                    else             r.tmo  = 1'b1;
                end
                expQ.push_back(r);
            end
        end else if (op == 7'h7F) begin
            r = '0;
            r.halted = 1'b1;
            r.flags  = modelFlags;
            for (int j = 0; j <= haltWait; j++) expQ.push_back(r);
        end else begin
            expQ.push_back(modelExec(op, modelFlags));
            if (modelSetsFlags(op)) modelFlags = fl;
        end

        opcode    = op;
        alu_flags = fl;
        start     = (op == 7'h7F) ? 1'b0 : rb();
        mem_ack   = rb();
        @(posedge clk); #1;
        start   = (op == 7'h7F) ? 1'b0 : rb();
        mem_ack = rb();
        @(posedge clk); #1;
        start   = 1'b0;
        mem_ack = 1'b0;
        if (isMem) begin
            for (int j = 1; j <= n; j++) begin
                mem_ack   = (j == ackAt);
                alu_flags = 4'($urandom);
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end else if (op == 7'h7F) begin
            repeat (haltWait) begin
                @(posedge clk); #1;
            end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic pulseStart();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: any strobe means the DUT is presenting a cycle result, which
    // must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        rec_t cur;
        rec_t exp;
        if (monitorOn && rst_n) begin
            cur = '{aluOp: alu_op, muxA: muxA_sel, muxB: muxB_sel,
                    regA: regA_load, regB: regB_load, pcInc: pc_inc,
                    pcLoad: pc_load, memReq: mem_req, memWe: mem_we,
                    halted: halted, illegal: illegal_op, tmo: mem_timeout,
                    flags: flags_q};
            if (cur.pcInc || cur.pcLoad || cur.memReq || cur.halted ||
                cur.illegal || cur.tmo || cur.regA || cur.regB) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %0h expected none", cur);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("cycle_record", 32'(cur), 32'(exp));
                end
            end
        end
    end

    initial begin
        logic [6:0] op;
        int         sel;

        #12;
        checkOutput("reset_alu_op", 32'(alu_op), 32'h0);
        checkOutput("reset_strobes", {pc_inc, pc_load, mem_req, regA_load, regB_load},
                    32'h0);
        checkOutput("reset_status", {halted, illegal_op, mem_timeout}, 32'h0);
        checkOutput("reset_flags", 32'(flags_q), 32'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        monitorOn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulseStart();

        applyStimulus(7'h06, 4'b1010, 0, 0);
        applyStimulus(7'h26, 4'b0001, 0, 0);
        applyStimulus(7'h28, 4'b0000, 0, 0);
        applyStimulus(7'h26, 4'b0000, 0, 0);
        applyStimulus(7'h28, 4'b0000, 0, 0);
        applyStimulus(7'h0B, 4'b0110, 0, 0);
        applyStimulus(7'h15, 4'b0010, 0, 0);
        applyStimulus(7'h2D, 4'b0000, 3, 0);
        applyStimulus(7'h2E, 4'b0000, MT + 1, 0);
        applyStimulus(7'h50, 4'b0000, 0, 0);
        applyStimulus(7'h7F, 4'b0000, 0, 2);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55)      op = 7'($urandom_range(0, 7'h26));
            else if (sel < 75) op = 7'($urandom_range(7'h27, 7'h2C));
            else if (sel < 87) op = rb() ? 7'h2D : 7'h2E;
            else if (sel < 92) op = 7'h7F;
            else               op = 7'($urandom_range(7'h2F, 7'h7E));
            applyStimulus(op, 4'($urandom), $urandom_range(1, MT + 1),
                          $urandom_range(0, 3));
        end

        applyStimulus(7'h26, 4'b0001, 0, 0);
        monitorOn = 1'b0;
        checkOutput("queue_drained_main", 32'(expQ.size()), 32'h0);

        opcode  = 7'h2D;
        mem_ack = 1'b0;
        start   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checkOutput("mem_req_before_reset", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mem_req_async_drop", 32'(mem_req), 32'h0);
        checkOutput("flags_async_clear", 32'(flags_q), 32'h0);
        #2;
        rst_n = 1'b1;
        modelFlags = '0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_after_reset", {pc_inc, pc_load, mem_req, halted}, 32'h0);
        end

        monitorOn = 1'b1;
        pulseStart();
        applyStimulus(7'h28, 4'b0000, 0, 0);
        applyStimulus(7'h2E, 4'b0000, MT + 1, 0);
        applyStimulus(7'h7F, 4'b0000, 0, 1);
        monitorOn = 1'b0;
        checkOutput("queue_drained_end", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
